// File: rtl/ram_pkg.sv
// Shared types and helpers for the flip-flop multi-port RAM.
// Byte merge is sized for the widest supported word; callers cast in and out.
package ram_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int MERGE_W = 512;
    localparam int MERGE_B = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_dat,
        input logic [MERGE_W-1:0] new_dat,
        input logic [MERGE_B-1:0] mask
    );
        logic [MERGE_W-1:0] res;
        res = old_dat;
        for (int b = 0; b < MERGE_B; b++) begin
            if (mask[b]) begin
                res[b*8 +: 8] = new_dat[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sweep sequencer: zeroes one entry per cycle after a clear_ request.
// Latency: busy rises the cycle after clear_ is sampled low, stays high DEPTH cycles.
// Backpressure: none; clear_ is ignored while a sweep is running.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int ADDR  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_,
    output logic            busy,
    output logic            clr_we,
    output logic [ADDR-1:0] clr_addr
);

    clr_state_t      state;
    logic [ADDR-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!clear_) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt == ADDR'(DEPTH - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ADDR'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = (state == CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/mp_ram.sv
// Flip-flop multi-port RAM with byte masks, per-byte write priority and a clear sweep.
// Latency: combinational read (OUTREG=0) or one registered cycle (OUTREG=1).
// Backpressure: none; while busy, user writes are dropped and reads return invalid.
module mp_ram
    import ram_pkg::*;
#(
    parameter  int DATA   = 32,
    parameter  int DEPTH  = 16,
    parameter  int RPORT  = 2,
    parameter  int WPORT  = 1,
    parameter  int OUTREG = 0,
    parameter  int BYPASS = 0,
    localparam int ADDR   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BYTES  = DATA / 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [RPORT-1:0]            ren_,
    input  logic [RPORT-1:0][ADDR-1:0]  raddr,
    output logic [RPORT-1:0][DATA-1:0]  rdata,
    output logic [RPORT-1:0]            rvalid,
    input  logic [WPORT-1:0]            wen_,
    input  logic [WPORT-1:0][ADDR-1:0]  waddr,
    input  logic [WPORT-1:0][BYTES-1:0] wmask,
    input  logic [WPORT-1:0][DATA-1:0]  wdata,
    input  logic                        clear_,
    output logic                        busy
);

    logic [DATA-1:0]            mem     [DEPTH];
    logic [DATA-1:0]            mem_nxt [DEPTH];
    logic [WPORT-1:0]           wr_ok;
    logic                       clr_we;
    logic [ADDR-1:0]            clr_addr;
    logic [RPORT-1:0][DATA-1:0] rd_dat;
    logic [RPORT-1:0]           rd_vld;

    ram_clear_seq #(
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clear_   (clear_),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    always_comb begin
        for (int j = 0; j < WPORT; j++) begin
            wr_ok[j] = !wen_[j] && !busy && (32'(waddr[j]) < DEPTH);
        end
    end

    // Ascending port order lets the highest index win each byte it masks in.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_nxt[e] = mem[e];
            for (int j = 0; j < WPORT; j++) begin
                if (wr_ok[j] && (32'(waddr[j]) == e)) begin
                    mem_nxt[e] = DATA'(byte_merge(MERGE_W'(mem_nxt[e]),
                                                  MERGE_W'(wdata[j]),
                                                  MERGE_B'(wmask[j])));
                end
            end
            if (clr_we && (32'(clr_addr) == e)) begin
                mem_nxt[e] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= mem_nxt[e];
            end
        end
    end

    // Reads are gated by reset so every output is zero while reset is held.
    // With bypass, mem_nxt already carries the collision-resolved same-cycle writes.
    always_comb begin
        for (int i = 0; i < RPORT; i++) begin
            rd_vld[i] = reset && !ren_[i] && !busy && (32'(raddr[i]) < DEPTH);
            rd_dat[i] = '0;
            if (rd_vld[i]) begin
                rd_dat[i] = (BYPASS != 0) ? mem_nxt[raddr[i]] : mem[raddr[i]];
            end
        end
    end

    generate
        if (OUTREG != 0) begin : g_oreg
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rdata  <= '0;
                    rvalid <= '0;
                end else begin
                    rdata  <= rd_dat;
                    rvalid <= rd_vld;
                end
            end
        end else begin : g_comb
            assign rdata  = rd_dat;
            assign rvalid = rd_vld;
        end
    endgenerate

endmodule

// File: tb/tb_mp_ram.sv
// Directed bench for mp_ram: three instances share stimulus (plain, bypass/DEPTH=12, output-registered).
module tb_mp_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [1:0]       ren_;
    logic [1:0][3:0]  raddr;
    logic [1:0]       wen_;
    logic [1:0][3:0]  waddr;
    logic [1:0][3:0]  wmask;
    logic [1:0][31:0] wdata;
    logic             clear_;

    logic [1:0][31:0] rdata_a, rdata_b, rdata_c;
    logic [1:0]       rvalid_a, rvalid_b, rvalid_c;
    logic             busy_a, busy_b, busy_c;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    mp_ram #(.DATA(32), .DEPTH(16), .RPORT(2), .WPORT(2), .OUTREG(0), .BYPASS(0)) dut_a (
        .clk(clk), .reset(reset), .ren_(ren_), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a),
        .wen_(wen_), .waddr(waddr), .wmask(wmask), .wdata(wdata), .clear_(clear_), .busy(busy_a));

    mp_ram #(.DATA(32), .DEPTH(12), .RPORT(2), .WPORT(2), .OUTREG(0), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .ren_(ren_), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b),
        .wen_(wen_), .waddr(waddr), .wmask(wmask), .wdata(wdata), .clear_(clear_), .busy(busy_b));

    mp_ram #(.DATA(32), .DEPTH(16), .RPORT(2), .WPORT(1), .OUTREG(1), .BYPASS(0)) dut_c (
        .clk(clk), .reset(reset), .ren_(ren_), .raddr(raddr), .rdata(rdata_c), .rvalid(rvalid_c),
        .wen_(wen_[0]), .waddr(waddr[0:0]), .wmask(wmask[0:0]), .wdata(wdata[0:0]),
        .clear_(clear_), .busy(busy_c));

    task automatic expect_rd(input logic v, input logic [31:0] d);
        exp_q.push_back({v, d});
    endtask

    task automatic check(input string tag, input logic [32:0] obs);
        logic [32:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed %h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic idle();
        ren_   = '1;
        wen_   = '1;
        wmask  = '0;
        clear_ = 1'b1;
    endtask

    task automatic wr(input int p, input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        wen_[p]  = 1'b0;
        waddr[p] = a;
        wdata[p] = d;
        wmask[p] = m;
    endtask

    task automatic rd(input int p, input logic [3:0] a);
        ren_[p]  = 1'b0;
        raddr[p] = a;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int na, nb, bad;

    initial begin
        reset = 1'b0;
        idle();
        raddr = '0;
        waddr = '0;
        wdata = '0;
        #2;
        expect_rd(1'b0, 32'h0); check("rst_a", {rvalid_a[0], rdata_a[0]});
        expect_rd(1'b0, 32'h0); check("rst_b", {rvalid_b[1], rdata_b[1]});
        expect_rd(1'b0, 32'h0); check("rst_c", {rvalid_c[0], rdata_c[0]});
        expect_rd(1'b0, 32'h0); check("rst_busy", {30'b0, busy_a, busy_b, busy_c});
        tick();
        reset = 1'b1;

        // byte-masked overwrite
        idle(); wr(0, 4'd3, 32'hAABBCCDD, 4'hF); tick();
        idle(); wr(0, 4'd3, 32'h11223344, 4'h5); tick();
        idle(); rd(0, 4'd3); #1;
        expect_rd(1'b1, 32'hAA22CC44); check("mask_a", {rvalid_a[0], rdata_a[0]});
        expect_rd(1'b1, 32'hAA22CC44); check("mask_b", {rvalid_b[0], rdata_b[0]});
        expect_rd(1'b1, 32'hAA22CC44);
        @(posedge clk); #1;
        check("mask_c", {rvalid_c[0], rdata_c[0]});
        tick();

        // two ports hitting one entry: port1 owns the low bytes
        idle(); wr(0, 4'd5, 32'h01010101, 4'hF); wr(1, 4'd5, 32'h02020202, 4'h3); tick();
        idle(); rd(1, 4'd5); #1;
        expect_rd(1'b1, 32'h01010202); check("collide_a", {rvalid_a[1], rdata_a[1]});
        expect_rd(1'b1, 32'h01010202); check("collide_b", {rvalid_b[1], rdata_b[1]});
        tick();

        // read-during-write
        idle(); wr(0, 4'd7, 32'hDEADBEEF, 4'hF); rd(0, 4'd7); #1;
        expect_rd(1'b1, 32'h0);        check("rdw_old_a", {rvalid_a[0], rdata_a[0]});
        expect_rd(1'b1, 32'hDEADBEEF); check("rdw_byp_b", {rvalid_b[0], rdata_b[0]});
        tick();
        idle(); rd(0, 4'd7); #1;
        expect_rd(1'b1, 32'hDEADBEEF); check("rdw_next_a", {rvalid_a[0], rdata_a[0]});
        tick();
        idle(); wr(0, 4'd7, 32'h11111111, 4'hC); wr(1, 4'd7, 32'h22222222, 4'h6); rd(1, 4'd7); #1;
        expect_rd(1'b1, 32'h112222EF); check("byp_merge_b", {rvalid_b[1], rdata_b[1]});
        expect_rd(1'b1, 32'hDEADBEEF); check("nobyp_old_a", {rvalid_a[1], rdata_a[1]});
        tick();
        idle(); rd(0, 4'd7); #1;
        expect_rd(1'b1, 32'h112222EF); check("merge_stored_a", {rvalid_a[0], rdata_a[0]});
        tick();

        // registered output: one cycle of latency
        idle(); wr(0, 4'd2, 32'h5A5A5A5A, 4'hF); tick();
        idle(); rd(0, 4'd2); #1;
        expect_rd(1'b0, 32'h0); check("oreg_cycleN_c", {rvalid_c[0], rdata_c[0]});
        expect_rd(1'b1, 32'h5A5A5A5A);
        @(posedge clk); #1;
        check("oreg_cycleN1_c", {rvalid_c[0], rdata_c[0]});
        tick();
        idle();
        expect_rd(1'b0, 32'h0);
        @(posedge clk); #1;
        check("oreg_drop_c", {rvalid_c[0], rdata_c[0]});
        tick();

        // full clear sweep
        for (int e = 0; e < 16; e++) begin
            idle(); wr(0, 4'(e), 32'hFFFFFFFF, 4'hF); tick();
        end
        idle(); clear_ = 1'b0; tick();
        na = 0; nb = 0; bad = 0;
        for (int k = 0; k < 24; k++) begin
            idle(); rd(0, 4'd0); rd(1, 4'd9);
            if (k == 4) wr(0, 4'd0, 32'h00001234, 4'hF);
            #1;
            if (busy_a) begin
                na++;
                if (rvalid_a != 2'b00 || rdata_a != '0) bad++;
            end
            if (busy_b) nb++;
            tick();
        end
        expect_rd(1'b0, 32'd16); check("busy_cycles_a", {1'b0, 32'(na)});
        expect_rd(1'b0, 32'd12); check("busy_cycles_b", {1'b0, 32'(nb)});
        expect_rd(1'b0, 32'd0);  check("sweep_reads_a", {1'b0, 32'(bad)});
        for (int e = 0; e < 16; e++) begin
            idle(); rd(0, 4'(e)); #1;
            expect_rd(1'b1, 32'h0); check("cleared_a", {rvalid_a[0], rdata_a[0]});
            expect_rd(e < 12, 32'h0); check("cleared_b", {rvalid_b[0], rdata_b[0]});
            tick();
        end

        // reset in cycle 6 of a sweep
        for (int e = 0; e < 12; e++) begin
            idle(); wr(0, 4'(e), 32'hFFFFFFFF, 4'hF); tick();
        end
        idle(); clear_ = 1'b0; tick();
        idle();
        for (int k = 0; k < 5; k++) tick();
        rd(0, 4'd9); #1;
        expect_rd(1'b0, 32'd1); check("busy_mid_b", {32'b0, busy_b});
        reset = 1'b0; #1;
        expect_rd(1'b0, 32'h0); check("rst_busy_b", {32'b0, busy_b});
        expect_rd(1'b0, 32'h0); check("rst_out_b", {rvalid_b[0], rdata_b[0]});
        tick();
        reset = 1'b1;
        for (int e = 0; e < 12; e++) begin
            idle(); rd(0, 4'(e)); #1;
            expect_rd(1'b1, 32'h0); check("rst_entry_b", {rvalid_b[0], rdata_b[0]});
            tick();
        end

        // out-of-range address on the 12-deep instance
        idle(); wr(0, 4'd13, 32'h0000CAFE, 4'hF); tick();
        idle(); rd(0, 4'd13); #1;
        expect_rd(1'b0, 32'h0);        check("range_b", {rvalid_b[0], rdata_b[0]});
        expect_rd(1'b1, 32'h0000CAFE); check("range_a", {rvalid_a[0], rdata_a[0]});
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mp_ram.md
Name: mp_ram

Overview:
- Flip-flop based multi-port RAM with independent read-port and write-port counts, per-byte write masks and deterministic write-collision priority.
- Selectable read-during-write bypass and optional output register, with a read-valid pipeline per port.
- A clear sequencer zeroes the array on request at one entry per cycle.
- Sits alongside existing register-file/RAM primitives; used for rename tables, small caches and queue storage.

Parameters:
- DATA, 32, data width in bits; must be a multiple of 8.
- DEPTH, 16, number of entries; need not be a power of two.
- RPORT, 2, number of read ports.
- WPORT, 1, number of write ports.
- OUTREG, 0, if 1, read data and rvalid are registered (1-cycle latency).
- BYPASS, 0, if 1, a same-cycle write to the read address is forwarded to read data.
- ADDR, $clog2(DEPTH), constant, address width.
- BYTES, DATA/8, constant, byte-mask width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- ren_  input  RPORT  per-port read enable, active low.
- raddr  input  RPORT x ADDR  read address.
- rdata  output  RPORT x DATA  read data.
- rvalid  output  RPORT  read data valid.
- wen_  input  WPORT  per-port write enable, active low.
- waddr  input  WPORT x ADDR  write address.
- wmask  input  WPORT x BYTES  byte write mask, active high.
- wdata  input  WPORT x DATA  write data.
- clear_  input  1  clear request, active low, sampled on clk.
- busy  output  1  clear sweep in progress.

Behaviour:
- Reset: all entries, rdata, rvalid and the clear counter go to 0; busy is 0; the FSM enters IDLE.
- Reset asserted mid-sweep aborts the sweep immediately.
- Write:
  - On the clk edge with wen_[j]=0, busy=0 and waddr[j]<DEPTH, each byte b with wmask[j][b]=1 is updated.
  - Bytes with a mask bit of 0 keep their value.
  - An all-zero mask is a no-op.
- Write collision: if several ports write the same byte of the same entry, the highest port index wins, resolved per byte.
- Read, combinational path:
  - Valid read when ren_[i]=0, busy=0 and raddr[i]<DEPTH.
  - rdata[i] = entry at raddr[i]; rvalid[i]=1.
  - Otherwise rdata[i]=0 and rvalid[i]=0.
- Out-of-range address (raddr or waddr >= DEPTH): writes are dropped; reads return 0 with rvalid=0.
- BYPASS=0: a read of an address being written in the same cycle returns the old contents.
- BYPASS=1: the read returns the merged value, i.e. old bytes overlaid with the collision-resolved written bytes. This is a combinational path from wdata to rdata.
- OUTREG=1: the combinational rdata and rvalid values are registered on clk, giving 1-cycle latency. Invalid cycles register 0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clear_=0 is sampled. The counter loads 0.
  - Writes presented in that same cycle still complete. Reads in that cycle are normal.
  - In CLEAR, each cycle writes 0 to the entry at the counter, then increments the counter.
  - busy=1 for exactly DEPTH cycles.
  - All user writes are dropped. All reads give rvalid=0 and rdata=0.
  - CLEAR -> IDLE after entry DEPTH-1 is written; busy falls on the next cycle.
  - clear_ held low in CLEAR is ignored; it does not restart the sweep.
  - clear_ still low in the first IDLE cycle starts a new sweep.
- busy is a registered output decoded from the state. There is no combinational path from clear_ to busy.

Decomposition:
- Package ram_pkg holds:
  - typedef enum for clear state {IDLE, CLEAR};
  - a byte-merge function (old, new, mask) -> data, used by both the write path and the bypass path.
- Sub-module ram_clear_seq: FSM plus the ADDR-bit counter. Outputs busy, clr_we and clr_addr.
- mp_ram instantiates ram_clear_seq and holds the array, write resolution, read mux and output stage.

Test Plan:
- Mask write (DATA=32, DEPTH=16, RPORT=2, WPORT=1):
  - Write 0xAABBCCDD to addr 3 with mask 4'b1111, then 0x11223344 with mask 4'b0101.
  - Read addr 3 must return 0xAA22CC44 with rvalid=1.
- Collision (WPORT=2):
  - Same cycle: port0 writes 0x01010101 to addr 5 with mask 4'b1111; port1 writes 0x02020202 with mask 4'b0011.
  - Addr 5 must then read 0x01010202.
- Bypass, with entry 7 = 0x0 and a same-cycle write of 0xDEADBEEF to addr 7 plus a read of addr 7:
  - BYPASS=1: same-cycle rdata = 0xDEADBEEF.
  - BYPASS=0: same-cycle rdata = 0x0, and 0xDEADBEEF on the next read.
- OUTREG=1: read addr 2 (holding 0x5A5A5A5A) in cycle N -> rdata=0x5A5A5A5A and rvalid=1 in cycle N+1; rvalid=0 in cycle N.
- Clear:
  - Fill all 16 entries with 0xFFFFFFFF, then pulse clear_ for one cycle.
  - busy must be high for exactly 16 cycles; a write of 0x1234 to addr 0 in cycle 5 of the sweep is dropped; reads during the sweep give rvalid=0.
  - After the sweep, every entry reads 0.
- Reset and range:
  - With DEPTH=12, assert reset at cycle 6 of a sweep: busy=0, all outputs 0 and all entries 0 immediately.
  - After reset, a write of 0xCAFE to addr 13 is dropped, and a read of addr 13 returns rvalid=0 with rdata=0.
